// File: rtl/cdbus_arb_pkg.sv
// cdbus_arb_pkg: shared widths and FSM state type
// for the cdbus CSR port arbiter.
package cdbus_arb_pkg;

  localparam int CDBUS_CSR_ADDR_W = 5;
  localparam int CDBUS_CSR_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

endpackage

// File: rtl/cdbus_rr_pick.sv
// cdbus_rr_pick: combinational round-robin picker,
// searching last+1, last+2, ... mod N_REQ.
module cdbus_rr_pick #(
  parameter int N_REQ = 3,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] elig,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             any
);

  if (N_REQ == 1) begin : g_one
    assign grant = elig;
    assign idx   = '0;
    assign any   = elig[0];
  end else begin : g_rr
    logic [IW:0]   sum;
    logic [IW-1:0] j;

    always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      sum   = '0;
      j     = '0;
      for (int k = 1; k <= N_REQ; k++) begin
        sum = {1'b0, last} + (IW+1)'(k);
        if (sum >= (IW+1)'(N_REQ))
          sum = sum - (IW+1)'(N_REQ);
        j = sum[IW-1:0];
        if (!any && elig[j]) begin
          any      = 1'b1;
          grant[j] = 1'b1;
          idx      = j;
        end
      end
    end
  end

endmodule

// File: rtl/cdbus_csr_arbiter.sv
// cdbus_csr_arbiter: round-robin share of one cdbus CSR port.
// Define CDBUS_ARB_LOCK_EN to add the req_lock grant-hold port.
module cdbus_csr_arbiter
  import cdbus_arb_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int READ_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_write,
  input  logic [N_REQ*5-1:0]      req_addr,
  input  logic [N_REQ*8-1:0]      req_wdata,
`ifdef CDBUS_ARB_LOCK_EN
  input  logic [N_REQ-1:0]        req_lock,
`endif
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [7:0]              rsp_rdata,
  output logic                    chip_select,
  output logic [4:0]              csr_address,
  output logic                    csr_read,
  output logic                    csr_write,
  output logic [7:0]              csr_writedata,
  input  logic [7:0]              csr_readdata
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int AW = CDBUS_CSR_ADDR_W;
  localparam int DW = CDBUS_CSR_DATA_W;

  arb_state_t       state;
  logic [IW-1:0]    last;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    w_idx;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] w_grant;
  logic             w_any;
  logic             can_take;
  logic             accept;
  logic [1:0]       cnt;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_wdata;

`ifdef CDBUS_ARB_LOCK_EN
  logic lock_on;

  // while locked only the owner is accepted, so last is the owner
  always_comb begin
    elig = req_valid;
    if (lock_on)
      elig = req_valid & (N_REQ'(1) << last);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      lock_on <= 1'b0;
    else if (accept)
      lock_on <= req_lock[w_idx];
  end
`else
  assign elig = req_valid;
`endif

  cdbus_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .elig  (elig),
    .last  (last),
    .grant (w_grant),
    .idx   (w_idx),
    .any   (w_any)
  );

  // a write finishes in ISSUE, so the next one may overlap it
  assign can_take  = (state == IDLE) ||
                     (state == ISSUE && csr_write);
  assign accept    = can_take && w_any;
  assign req_ready = accept ? w_grant : '0;
  assign w_addr    = req_addr[int'(w_idx)*AW +: AW];
  assign w_wdata   = req_wdata[int'(w_idx)*DW +: DW];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      last          <= IW'(N_REQ-1);
      owner         <= '0;
      cnt           <= '0;
      chip_select   <= 1'b0;
      csr_read      <= 1'b0;
      csr_write     <= 1'b0;
      csr_address   <= '0;
      csr_writedata <= '0;
      rsp_valid     <= '0;
      rsp_rdata     <= '0;
    end else begin
      chip_select <= 1'b0;
      csr_read    <= 1'b0;
      csr_write   <= 1'b0;
      rsp_valid   <= '0;
      if (accept) begin
        chip_select   <= 1'b1;
        csr_write     <= req_write[w_idx];
        csr_read      <= !req_write[w_idx];
        csr_address   <= w_addr;
        csr_writedata <= w_wdata;
        last          <= w_idx;
        owner         <= w_idx;
      end
      unique case (state)
        IDLE: begin
          if (accept)
            state <= ISSUE;
        end
        ISSUE: begin
          if (!csr_write) begin
            state <= WAIT;
            cnt   <= 2'(READ_LAT-1);
          end else if (!accept) begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt == 2'd0) begin
            rsp_valid <= N_REQ'(1) << owner;
            rsp_rdata <= csr_readdata;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdbus_csr_arbiter.sv
// tb_cdbus_csr_arbiter: random and directed traffic against a
// cycle-level reference model, checked by a scoreboard monitor.
module tb_cdbus_csr_arbiter;

  localparam int N  = 3;
  localparam int RL = 2;

  typedef struct packed {
    logic       w;
    logic [4:0] a;
    logic [7:0] d;
    logic       l;
  } req_t;
  typedef struct packed {
    int         cyc;
    logic [4:0] a;
    logic       w;
    logic [7:0] d;
  } stb_t;
  typedef struct packed {
    int         cyc;
    logic [N-1:0] v;
    logic [7:0] d;
  } rsp_t;
  typedef struct packed {
    int         cyc;
    logic [N-1:0] r;
  } rdy_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_write = '0;
  logic [N*5-1:0] req_addr = '0;
  logic [N*8-1:0] req_wdata = '0;
`ifdef CDBUS_ARB_LOCK_EN
  logic [N-1:0]   req_lock = '0;
`endif
  logic [N-1:0]   rsp_valid;
  logic [7:0]     rsp_rdata;
  logic           chip_select;
  logic [4:0]     csr_address;
  logic           csr_read;
  logic           csr_write;
  logic [7:0]     csr_writedata;
  logic [7:0]     csr_readdata = '0;

  always #5 clk = ~clk;

  cdbus_csr_arbiter #(.N_REQ(N), .READ_LAT(RL)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
`ifdef CDBUS_ARB_LOCK_EN
    .req_lock      (req_lock),
`endif
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .chip_select   (chip_select),
    .csr_address   (csr_address),
    .csr_read      (csr_read),
    .csr_write     (csr_write),
    .csr_writedata (csr_writedata),
    .csr_readdata  (csr_readdata)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] slave_f(input logic [4:0] a);
    return {3'b101, a};
  endfunction

  // slave: data valid only in the cycle READ_LAT after the strobe
  int sched = -1;
  logic [4:0] sa = '0;
  always @(posedge clk) begin
    #1;
    if (!reset_n) sched = -1;
    else if (csr_read) begin
      sched = cyc + RL;
      sa = csr_address;
    end
    csr_readdata = (cyc == sched) ? slave_f(sa) : 8'($urandom);
  end

  stb_t stbq[$];
  rsp_t rspq[$];
  rdy_t rdyq[$];

  // ---------------- reference model and stimulus ----------------
  req_t pend[N][4];
  int   pc[N];
  int   m_last = N - 1;
  int   m_free = 0;
  logic m_lock = 1'b0;
  logic m_acc = 1'b0;
  logic rand_mode = 1'b0;
  logic fin_req = 1'b0;

  task automatic post(input int i, input logic w, input logic [4:0] a,
                      input logic [7:0] d, input logic l);
    if (pc[i] < 4) begin
      pend[i][pc[i]] = '{w: w, a: a, d: d, l: l};
      pc[i]++;
    end
  endtask

  task automatic retire(input int i);
    for (int k = 0; k < 3; k++) pend[i][k] = pend[i][k+1];
    pc[i]--;
  endtask

  task automatic drive();
    logic lk;
    for (int i = 0; i < N; i++) begin
      logic dropped;
      dropped = 1'b0;
      if (rand_mode) begin
        if (pc[i] > 0 && $urandom_range(0, 15) == 0) begin
          retire(i);
          dropped = 1'b1;
        end else if (pc[i] == 0 && $urandom_range(0, 2) == 0) begin
`ifdef CDBUS_ARB_LOCK_EN
          lk = ($urandom_range(0, 3) == 0);
`else
          lk = 1'b0;
`endif
          post(i, 1'($urandom_range(0, 1)), 5'($urandom),
               8'($urandom), lk);
        end
      end
      req_valid[i] = (pc[i] > 0) && !dropped;
      req_write[i] = pend[i][0].w;
      req_addr[i*5 +: 5] = pend[i][0].a;
      req_wdata[i*8 +: 8] = pend[i][0].d;
`ifdef CDBUS_ARB_LOCK_EN
      req_lock[i] = pend[i][0].l;
`endif
    end
  endtask

  task automatic model();
    logic [N-1:0] el;
    int w;
    rdy_t e;
    stb_t s;
    rsp_t r;
    el = req_valid;
    if (m_lock) el = el & (N'(1) << m_last);
    w = -1;
    if (cyc >= m_free)
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (w < 0 && el[j]) w = j;
      end
    e.cyc = cyc;
    e.r = (w < 0) ? '0 : (N'(1) << w);
    rdyq.push_back(e);
    if (w >= 0) begin
      s.cyc = cyc + 1;
      s.a = pend[w][0].a;
      s.w = pend[w][0].w;
      s.d = pend[w][0].d;
      stbq.push_back(s);
      if (!pend[w][0].w) begin
        r.cyc = cyc + 2 + RL;
        r.v = N'(1) << w;
        r.d = slave_f(pend[w][0].a);
        rspq.push_back(r);
        m_free = cyc + 2 + RL;
        m_acc = 1'b1;
      end else begin
        m_free = cyc + 1;
      end
      m_lock = pend[w][0].l;
      m_last = w;
      retire(w);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    model();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drain();
    rand_mode = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (m_lock && pc[m_last] == 0) post(m_last, 1'b1, 5'h1f, 8'h00, 1'b0);
      step();
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    m_last = N - 1;
    m_free = 0;
    m_lock = 1'b0;
    reset_n = 1'b1;
    in_rst = 1'b0;
    drive();
    model();
  endtask

  initial begin
    for (int i = 0; i < N; i++) pc[i] = 0;
    repeat (3) @(posedge clk);
    release_reset();
    // three simultaneous writes
    post(0, 1'b1, 5'h01, 8'h10, 1'b0);
    post(1, 1'b1, 5'h02, 8'h20, 1'b0);
    post(2, 1'b1, 5'h03, 8'h30, 1'b0);
    run(6);
    // single read from requester 1
    post(1, 1'b0, 5'h05, 8'h00, 1'b0);
    run(8);
    // two requesters continuously valid
    for (int k = 0; k < 4; k++) begin
      post(0, 1'b1, 5'(k), 8'(k), 1'b0);
      post(2, k[0], 5'(k + 8), 8'(k + 8), 1'b0);
    end
    run(24);
`ifdef CDBUS_ARB_LOCK_EN
    post(2, 1'b1, 5'h11, 8'h01, 1'b1);
    post(2, 1'b1, 5'h12, 8'h02, 1'b1);
    post(2, 1'b1, 5'h13, 8'h03, 1'b0);
    run(1);
    post(0, 1'b1, 5'h0a, 8'haa, 1'b0);
    post(0, 1'b1, 5'h0b, 8'hbb, 1'b0);
    run(10);
`endif
    rand_mode = 1'b1;
    run(1500);
    drain();
    // reset asserted while a read is waiting
    m_acc = 1'b0;
    post(0, 1'b0, 5'h09, 8'h00, 1'b0);
    for (int t = 0; t < 20 && !m_acc; t++) step();
    if (!m_acc) begin
      $display("FAIL mid_read_accept: read never accepted, required accept");
      $fatal(1);
    end
    step();
    step();
    #1;
    in_rst = 1'b1;
    reset_n = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) pc[i] = 0;
    repeat (2) @(posedge clk);
    release_reset();
    post(2, 1'b1, 5'h17, 8'h77, 1'b0);
    post(1, 1'b1, 5'h16, 8'h66, 1'b0);
    post(0, 1'b1, 5'h15, 8'h55, 1'b0);
    run(RL + 8);
    drain();
    fin_req = 1'b1;
    run(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- monitor / scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic fin_done = 1'b0;
  logic [4:0] h_addr = '0;
  logic [7:0] h_wd = '0;
  logic [7:0] h_rd = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    stb_t s;
    rsp_t r;
    if (in_rst) begin
      stbq.delete();
      rspq.delete();
      rdyq.delete();
      h_addr = '0;
      h_wd = '0;
      h_rd = '0;
      if (!reset_n) begin
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
        chk("rst_chip_select", 32'(chip_select), 32'(0));
        chk("rst_csr_read", 32'(csr_read), 32'(0));
        chk("rst_csr_write", 32'(csr_write), 32'(0));
        chk("rst_csr_address", 32'(csr_address), 32'(0));
        chk("rst_csr_writedata", 32'(csr_writedata), 32'(0));
      end
    end else begin
      if (rdyq.size() > 0) begin
        chk("ready_cycle", 32'(rdyq[0].cyc), 32'(cyc));
        chk("req_ready", 32'(req_ready), 32'(rdyq[0].r));
        void'(rdyq.pop_front());
      end else begin
        chk("ready_missing_model", 32'(rdyq.size()), 32'(1));
      end
      if (stbq.size() > 0 && stbq[0].cyc == cyc) begin
        s = stbq.pop_front();
        chk("chip_select", 32'(chip_select), 32'(1));
        chk("csr_write", 32'(csr_write), 32'(s.w));
        chk("csr_read", 32'(csr_read), 32'(!s.w));
        h_addr = s.a;
        h_wd = s.d;
      end else begin
        chk("idle_chip_select", 32'(chip_select), 32'(0));
        chk("idle_csr_read", 32'(csr_read), 32'(0));
        chk("idle_csr_write", 32'(csr_write), 32'(0));
      end
      chk("csr_address", 32'(csr_address), 32'(h_addr));
      chk("csr_writedata", 32'(csr_writedata), 32'(h_wd));
      if (rspq.size() > 0 && rspq[0].cyc == cyc) begin
        r = rspq.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(r.v));
        h_rd = r.d;
      end else begin
        chk("idle_rsp_valid", 32'(rsp_valid), 32'(0));
      end
      chk("rsp_rdata", 32'(rsp_rdata), 32'(h_rd));
      if (fin_req && !fin_done) begin
        chk("strobes_left", 32'(stbq.size()), 32'(0));
        chk("responses_left", 32'(rspq.size()), 32'(0));
        fin_done = 1'b1;
      end
    end
  end

endmodule
